action_arbiter: RTL and testbench

Arbitrates user care-button requests into single-cycle action pulses for the pet statistics block. Captures press edges per action, grants one action at a time round-robin, and enforces a cooldown between grants. Its `act` output drives the statistics block's 8-bit `inputs` bus directly, so a held button cannot decrement a stat every clock.

---
 rtl/action_arbiter.sv | 161 ++++++++++++++++
 tb/tb_action_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/action_arbiter.sv
// ---------------------------------------------------------------------------
// action_arbiter
//
// Turns debounced care-button levels into single-cycle action pulses for the
// pet statistics block. Each rising edge of a request is captured as a
// pending bit. Pending actions are granted one at a time in round-robin
// order. Every grant is followed by an enforced idle (cooldown) period, so a
// held button can never hit a stat every clock.
//
// Optional feature: define ACTION_ENERGY_LOCKOUT_EN to mask every action
// except energy/sleep (bit 4) out of arbitration while energy == 0. Masked
// actions stay pending and are granted once energy is nonzero again. Without
// the macro the energy port is accepted and ignored.
//
// Parameters
//   COOLDOWN   idle cycles after each grant (1..65535)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   req[5:0]   request levels (0 hunger, 1 happiness, 2 health, 3 hygiene,
//              4 energy/sleep, 5 social)
//   energy     current energy stat (used only with the lockout feature)
//   act[7:0]   registered one-hot action pulse, bits 7:6 always 0
//   busy       high while the cooldown runs (mirrors the COOL state)
//   pending    captured, not-yet-granted requests
//   grant_idx  index of the last granted action (5 after reset)
//   drop_cnt   saturating count of presses on already-pending actions
//
// Output contract: act is a pulse, not a handshake. The consumer cannot
// stall it. At most one bit is set, for exactly one cycle per grant, and
// the same cycle busy rises. busy then stays high for COOLDOWN cycles.
// ---------------------------------------------------------------------------
module action_arbiter #(
    parameter int COOLDOWN = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] req,
    input  logic [3:0] energy,
    output logic [7:0] act,
    output logic       busy,
    output logic [5:0] pending,
    output logic [2:0] grant_idx,
    output logic [7:0] drop_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        COOL = 1'b1
    } state_t;

    localparam logic [15:0] CNT_LOAD = 16'(COOLDOWN - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [5:0]  req_q;
    logic [5:0]  req_edge;
    logic [5:0]  eligible;
    logic [5:0]  win_mask;
    logic [2:0]  win_idx;
    logic        found;
    logic [3:0]  s;
    logic        grant_fire;
    logic [5:0]  clr_mask;
    logic [5:0]  dup;
    logic [2:0]  dup_n;
    logic [8:0]  drop_sum;

    assign req_edge = req & ~req_q;

`ifdef ACTION_ENERGY_LOCKOUT_EN
    // Out of energy: only sleep may be granted, the rest wait in pending.
    assign eligible = (energy == 4'd0) ? (pending & 6'b01_0000) : pending;
`else
    logic unused_energy;
    assign unused_energy = ^energy;
    assign eligible      = pending;
`endif

    // Round-robin search starting one past the last grant, wrapping 5 -> 0.
    always_comb begin
        win_mask = '0;
        win_idx  = grant_idx;
        found    = 1'b0;
        s        = '0;
        for (int k = 1; k <= 6; k++) begin
            s = {1'b0, grant_idx} + 4'(k);
            if (s >= 4'd6) begin
                s = s - 4'd6;
            end
            if (!found && eligible[s[2:0]]) begin
                found             = 1'b1;
                win_idx           = s[2:0];
                win_mask[s[2:0]]  = 1'b1;
            end
        end
    end

    assign grant_fire = (state == IDLE) && found;
    assign clr_mask   = grant_fire ? win_mask : 6'b0;

    // A press on a bit that is being granted this cycle is re-queued, not
    // dropped, so the winner's bit is excluded from the duplicate test.
    assign dup = req_edge & pending & ~clr_mask;

    always_comb begin
        dup_n = '0;
        for (int i = 0; i < 6; i++) begin
            dup_n = dup_n + {2'b00, dup[i]};
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + {6'b0, dup_n};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= '0;
            pending   <= '0;
            act       <= '0;
            busy      <= 1'b0;
            grant_idx <= 3'd5;
            drop_cnt  <= '0;
        end else begin
            req_q    <= req;
            // Set wins over clear: a re-press on the granted bit stays queued.
            pending  <= (pending & ~clr_mask) | req_edge;
            drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        act       <= {2'b00, win_mask};
                        grant_idx <= win_idx;
                        cnt       <= CNT_LOAD;
                        busy      <= 1'b1;
                        state     <= COOL;
                    end else begin
                        act <= '0;
                    end
                end
                COOL: begin
                    act <= '0;
                    if (cnt == 16'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    act   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_action_arbiter.sv
// ---------------------------------------------------------------------------
// tb_action_arbiter
//
// Self-checking bench for action_arbiter with COOLDOWN = 4.
// A reference model updates on every rising edge. It keeps pending requests
// as a bit array, holds the remaining busy cycles as an integer, and finds
// the next grant with a modulo-6 scan. Each predicted grant is pushed onto
// exp_q. A monitor on the falling edge pops exp_q whenever act is nonzero.
// The monitor also compares busy, pending, grant_idx and drop_cnt with the
// model every cycle. Directed scenarios come first, then random phases.
// ---------------------------------------------------------------------------
module tb_action_arbiter;

    localparam int CD = 4;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [5:0] req    = '0;
    logic [3:0] energy = 4'd5;
    logic [7:0] act;
    logic       busy;
    logic [5:0] pending;
    logic [2:0] grant_idx;
    logic [7:0] drop_cnt;

    action_arbiter #(.COOLDOWN(CD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .energy    (energy),
        .act       (act),
        .busy      (busy),
        .pending   (pending),
        .grant_idx (grant_idx),
        .drop_cnt  (drop_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [7:0] act;
        logic [2:0] gidx;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   n_pulses = 0;
    int   gcount[6];

    // ---------------- reference model state ----------------
    bit       m_pend[6];
    int       m_cool;
    int       m_last;
    int       m_drop;
    bit [5:0] m_prev;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [5:0] m_pend_vec();
        logic [5:0] v;
        for (int i = 0; i < 6; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit elig(int i);
`ifdef ACTION_ENERGY_LOCKOUT_EN
        return (i == 4) || (energy != 4'd0);
`else
        return (i >= 0);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_pend[i] = 1'b0;
        m_cool = 0;
        m_last = 5;
        m_drop = 0;
        m_prev = '0;
        exp_q.delete();
    endtask

    // Reference model: predicts each rising edge from the rules.
    always @(posedge clk) begin
        int       win;
        int       idx;
        exp_t     x;
        bit [5:0] e;
        if (!reset) begin
            cyc++;
            e   = req & ~m_prev;
            win = -1;
            if (m_cool == 0) begin
                for (int k = 1; k <= 6; k++) begin
                    idx = (m_last + k) % 6;
                    if (win < 0 && m_pend[idx] && elig(idx)) win = idx;
                end
                if (win >= 0) begin
                    m_pend[win] = 1'b0;
                    m_cool      = CD;
                    m_last      = win;
                    x.act       = 8'd1 << win;
                    x.gidx      = 3'(win);
                    x.cyc       = cyc;
                    exp_q.push_back(x);
                end
            end else begin
                m_cool--;
            end
            for (int i = 0; i < 6; i++) begin
                if (e[i]) begin
                    if (m_pend[i]) begin
                        if (m_drop < 255) m_drop++;
                    end else begin
                        m_pend[i] = 1'b1;
                    end
                end
            end
            m_prev = req;
        end
    end

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t x;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            x = exp_q.pop_front();
            chk("act_missing", 32'h0, {24'h0, x.act});
        end
        if (act != 8'h00) begin
            n_pulses++;
            for (int i = 0; i < 6; i++) if (act[i]) gcount[i]++;
            if (exp_q.size() == 0) begin
                chk("act_unexpected", {24'h0, act}, 32'h0);
            end else begin
                x = exp_q.pop_front();
                chk("act_value", {24'h0, act}, {24'h0, x.act});
                chk("act_cycle", cyc, x.cyc);
            end
        end
        chk("busy",      {31'h0, busy},      {31'h0, (m_cool > 0)});
        chk("pending",   {26'h0, pending},   {26'h0, m_pend_vec()});
        chk("grant_idx", {29'h0, grant_idx}, m_last);
        chk("drop_cnt",  {24'h0, drop_cnt},  m_drop);
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic [5:0] hold_req, input int ncyc);
        @(negedge clk);
        #2;
        reset = 1'b1;
        req   = hold_req;
        model_reset();
        repeat (ncyc) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic press(input logic [5:0] v);
        @(negedge clk);
        req = v;
        @(negedge clk);
        req = '0;
    endtask

    // Counts falling edges until act == v; a timeout counts as a failure.
    task automatic cycles_to_act(input logic [7:0] v, input int max, input string name,
                                 output int n);
        n = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (act == v) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: act %02h not seen within %0d cycles, last act %02h", name, v, max, act);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int g;
        int p0;
        int bcount;
        for (int i = 0; i < 6; i++) gcount[i] = 0;
        model_reset();

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_act",       {24'h0, act},       32'h0);
        chk("rst_busy",      {31'h0, busy},      32'h0);
        chk("rst_pending",   {26'h0, pending},   32'h0);
        chk("rst_grant_idx", {29'h0, grant_idx}, 32'h5);
        chk("rst_drop_cnt",  {24'h0, drop_cnt},  32'h0);
        #2 reset = 1'b0;

        // Single press of action 2.
        @(negedge clk);
        req = 6'h04;
        @(negedge clk);
        req = '0;
        #1 chk("single_pending", {26'h0, pending}, 32'h04);
        @(negedge clk);
        #1 chk("single_act", {24'h0, act}, 32'h04);
        chk("single_gidx", {29'h0, grant_idx}, 32'h2);
        bcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) bcount++;
            @(negedge clk);
        end
        chk("single_busy_len", bcount, CD);

        // Round-robin with simultaneous requests 0, 3, 5.
        do_reset('0, 2);
        press(6'h29);
        cycles_to_act(8'h01, 4, "rr_first", n);
        cycles_to_act(8'h08, 10, "rr_second", n);
        chk("rr_gap_0_3", n, CD + 1);
        cycles_to_act(8'h20, 10, "rr_third", n);
        chk("rr_gap_3_5", n, CD + 1);

        // Held button: one grant only.
        do_reset('0, 2);
        g = gcount[1];
        @(negedge clk);
        req = 6'h02;
        repeat (100) @(negedge clk);
        req = '0;
        repeat (10) @(negedge clk);
        chk("held_grants", gcount[1] - g, 1);

        // Duplicate press of action 1 during action 0's cooldown.
        do_reset('0, 2);
        press(6'h01);
        cycles_to_act(8'h01, 5, "dup_grant0", n);
        req = 6'h02;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        req = 6'h02;
        @(negedge clk);
        req = '0;
        g = gcount[1];
        repeat (8) @(negedge clk);
        #1 chk("dup_drop_cnt", {24'h0, drop_cnt}, 32'h1);
        chk("dup_grants", gcount[1] - g, 1);

        // Re-press of action 4 on the edge that grants it.
        do_reset('0, 2);
        press(6'h01);
        cycles_to_act(8'h01, 5, "repress_grant0", n);
        req = 6'h10;
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 10 && m_cool != 0; i++) @(negedge clk);
        req = 6'h10;
        @(negedge clk);
        #1 chk("repress_act", {24'h0, act}, 32'h10);
        chk("repress_pending4", {31'h0, pending[4]}, 32'h1);
        req = '0;
        cycles_to_act(8'h10, 10, "repress_second", n);
        chk("repress_gap", n, CD + 1);

        // Reset two cycles into COOL with pending 0 and 5.
        do_reset('0, 2);
        press(6'h02);
        cycles_to_act(8'h02, 5, "midcool_grant1", n);
        req = 6'h21;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        #1 chk("midcool_pending", {26'h0, pending}, 32'h21);
        chk("midcool_busy", {31'h0, busy}, 32'h1);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_act",       {24'h0, act},       32'h0);
        chk("midrst_busy",      {31'h0, busy},      32'h0);
        chk("midrst_pending",   {26'h0, pending},   32'h0);
        chk("midrst_grant_idx", {29'h0, grant_idx}, 32'h5);
        chk("midrst_drop_cnt",  {24'h0, drop_cnt},  32'h0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        p0 = n_pulses;
        repeat (12) @(negedge clk);
        chk("no_act_after_reset", n_pulses - p0, 0);

        // A level held through reset release acts as a fresh edge.
        do_reset(6'h08, 2);
        cycles_to_act(8'h08, 5, "held_through_reset", n);
        req = '0;
        repeat (6) @(negedge clk);

`ifdef ACTION_ENERGY_LOCKOUT_EN
        // Energy lockout: only sleep may be granted while energy is 0.
        do_reset('0, 2);
        energy = 4'd0;
        press(6'h11);
        cycles_to_act(8'h10, 5, "lock_sleep", n);
        g = gcount[0];
        repeat (12) @(negedge clk);
        #1 chk("lock_pending", {26'h0, pending}, 32'h01);
        chk("lock_no_grant0", gcount[0] - g, 0);
        energy = 4'd3;
        cycles_to_act(8'h01, 3, "lock_release", n);
        chk("lock_release_lat", n, 1);
        energy = 4'd5;
        repeat (6) @(negedge clk);
`endif

        // Random: high activity, then drop_cnt must be saturated.
        do_reset('0, 2);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req    = req ^ 6'($urandom_range(0, 63));
            energy = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end
        @(negedge clk);
        #1 chk("drop_saturated", {24'h0, drop_cnt}, 32'hFF);

        // Random: low activity.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int b = 0; b < 6; b++) if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 7) == 0) energy = 4'($urandom_range(0, 15));
        end

        // Random: reset mid-run, then more traffic.
        do_reset(6'($urandom_range(0, 63)), 1);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            for (int b = 0; b < 6; b++) if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 7) == 0) energy = 4'($urandom_range(0, 15));
        end

        // Drain everything still pending.
        @(negedge clk);
        req    = '0;
        energy = 4'd5;
        repeat (60) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
